// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: main FSM, condition register and NZCV flags register.
// Optional macro MC_CMPTST_EN adds CMP/TST (flag-only ops that skip ALUWB).
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flags_q;
    logic        cond_q;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        unused_rn;

    logic [1:0]  alu_ctrl;
    logic        cmp_tst;
    logic        set_flags;
    logic        cond_ok;
    logic        pc_we, mem_we, reg_we, ir_we;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    always_comb begin
        alu_ctrl = 2'b00;
        cmp_tst  = 1'b0;
        case (funct[4:1])
            4'b0100: alu_ctrl = 2'b00;
            4'b0010: alu_ctrl = 2'b01;
            4'b0000: alu_ctrl = 2'b10;
            4'b1100: alu_ctrl = 2'b11;
`ifdef MC_CMPTST_EN
            4'b1010: begin
                alu_ctrl = 2'b01;
                cmp_tst  = 1'b1;
            end
            4'b1000: begin
                alu_ctrl = 2'b10;
                cmp_tst  = 1'b1;
            end
`endif
            default: alu_ctrl = 2'b00;
        endcase
    end

    assign set_flags = funct[0] | cmp_tst;

    // flags_q = {N, Z, C, V}
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = flags_q[2];
            4'h1: cond_ok = ~flags_q[2];
            4'h2: cond_ok = flags_q[1];
            4'h3: cond_ok = ~flags_q[1];
            4'h4: cond_ok = flags_q[3];
            4'h5: cond_ok = ~flags_q[3];
            4'h6: cond_ok = flags_q[0];
            4'h7: cond_ok = ~flags_q[0];
            4'h8: cond_ok = flags_q[1] & ~flags_q[2];
            4'h9: cond_ok = ~flags_q[1] | flags_q[2];
            4'hA: cond_ok = (flags_q[3] == flags_q[0]);
            4'hB: cond_ok = (flags_q[3] != flags_q[0]);
            4'hC: cond_ok = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'hD: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                cond_q <= cond_ok;
            end
            if ((state_q == StExecR || state_q == StExecI) && set_flags && cond_q) begin
                flags_q[3:2] <= ALUFlags[3:2];
                // C and V only carry meaning for arithmetic ops
                if (!alu_ctrl[1]) begin
                    flags_q[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    always_comb begin
        state_d    = StFetch;
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        ir_we      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            StFetch: begin
                state_d   = StDecode;
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_we    = cond_q;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                mem_we = cond_q;
            end
            StExecR, StExecI: begin
                ALUSrcB    = (state_q == StExecI) ? 2'b01 : 2'b00;
                ALUControl = alu_ctrl;
                state_d    = cmp_tst ? StFetch : StAluWb;
            end
            StAluWb: begin
                reg_we = cond_q;
                pc_we  = cond_q & (rd == 4'hF);
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = cond_q;
            end
            default: state_d = StFetch;
        endcase
    end

    // Gate with reset so nothing writes while the FSM is held in FETCH
    assign PCWrite  = pc_we & ~reset;
    assign MemWrite = mem_we & ~reset;
    assign RegWrite = reg_we & ~reset;
    assign IRWrite  = ir_we & ~reset;

    assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign ImmSrc = op;
    assign State  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random instruction stream
// compared against an instruction-level reference model.
module tb_mc_controller;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
    localparam int S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  State;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model architectural state
    logic [3:0] m_flags = 4'b0000;  // {N,Z,C,V}
    bit         m_cond = 1'b0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ARM conditions: odd codes negate the even code below them; 1110 always, 1111 never
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic bit is_cmptst(input logic [3:0] cmd);
`ifdef MC_CMPTST_EN
        return (cmd == 4'b1010) || (cmd == 4'b1000);
`else
        return (cmd == 4'b1111) && (cmd == 4'b0000);
`endif
    endfunction

    // 0 ADD, 1 SUB, 2 AND, 3 ORR
    function automatic logic [1:0] exp_alu(input logic [3:0] cmd);
        if (cmd == 4'b0010) return 2'd1;
        if (cmd == 4'b0000) return 2'd2;
        if (cmd == 4'b1100) return 2'd3;
        if (is_cmptst(cmd)) return (cmd == 4'b1010) ? 2'd1 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] fn, input logic [3:0] rn,
                                       input logic [3:0] rd);
        return {c, op, fn, rn, rd};
    endfunction

    task automatic build_seq(input logic [19:0] ins, output int seq[$]);
        logic [1:0] op;
        logic [5:0] fn;
        op = ins[15:14];
        fn = ins[13:8];
        seq = {S_FETCH, S_DECODE};
        case (op)
            2'b00: begin
                seq.push_back(fn[5] ? S_EXECI : S_EXECR);
                if (!is_cmptst(fn[4:1])) seq.push_back(S_ALUWB);
            end
            2'b01: begin
                seq.push_back(S_MEMADR);
                if (fn[0]) begin
                    seq.push_back(S_MEMRD);
                    seq.push_back(S_MEMWB);
                end else begin
                    seq.push_back(S_MEMWR);
                end
            end
            2'b10: seq.push_back(S_BRANCH);
            default: ;
        endcase
    endtask

    task automatic check_cycle(input int s, input logic [19:0] ins);
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] en;
        op = ins[15:14];
        fn = ins[13:8];
        en = 4'b0000;  // {PC, Mem, Reg, IR}
        case (s)
            S_FETCH:  en = 4'b1001;
            S_MEMWR:  en = {1'b0, m_cond, 2'b00};
            S_MEMWB:  en = {2'b00, m_cond, 1'b0};
            S_ALUWB:  en = {m_cond && (ins[3:0] == 4'hF), 1'b0, m_cond, 1'b0};
            S_BRANCH: en = {m_cond, 3'b000};
            default: ;
        endcase
        check("state", State, s);
        check("write_en", {PCWrite, MemWrite, RegWrite, IRWrite}, en);
        case (s)
            S_FETCH: begin
                check("fetch_mux", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl},
                      {1'b0, 1'b1, 2'b10, 2'b10, 2'b00});
            end
            S_DECODE: begin
                check("decode_mux", {ALUSrcA, ALUSrcB, ResultSrc, ALUControl},
                      {1'b1, 2'b10, 2'b10, 2'b00});
                check("regsrc", RegSrc, {op == 2'b01 && !fn[0], op == 2'b10});
                check("immsrc", ImmSrc, op);
            end
            S_MEMADR: check("memadr_mux", {ALUSrcA, ALUSrcB, ALUControl}, {1'b0, 2'b01, 2'b00});
            S_MEMRD, S_MEMWR: check("mem_adrsrc", AdrSrc, 1);
            S_MEMWB: check("memwb_res", ResultSrc, 2'b01);
            S_EXECR, S_EXECI: begin
                check("exec_mux", {ALUSrcA, ALUSrcB},
                      {1'b0, (s == S_EXECI) ? 2'b01 : 2'b00});
                check("alu_ctrl", ALUControl, exp_alu(fn[4:1]));
            end
            S_ALUWB: check("aluwb_res", ResultSrc, 2'b00);
            S_BRANCH: begin
                check("branch_mux", {ALUSrcA, ALUSrcB, ResultSrc, ALUControl},
                      {1'b0, 2'b01, 2'b10, 2'b00});
            end
            default: ;
        endcase
    endtask

    // Runs one instruction; abort_k >= 0 asserts reset during that step of the sequence.
    task automatic run_instr(input logic [19:0] ins, input bit fixed, input logic [3:0] fl,
                             input int abort_k);
        int seq[$];
        logic [3:0] cmd;
        build_seq(ins, seq);
        cmd = ins[12:9];
        Instr = ins;
        foreach (seq[k]) begin
            ALUFlags = fixed ? fl : 4'($urandom);
            @(negedge clk);
            check_cycle(seq[k], ins);
            if (k == abort_k) begin
                #2 reset = 1'b1;
                #1;
                check("abort_we", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
                check("abort_state", State, S_FETCH);
                @(posedge clk);
                #1 reset = 1'b0;
                m_flags = 4'b0000;
                m_cond  = 1'b0;
                return;
            end
            if (seq[k] == S_DECODE) begin
                m_cond = cond_holds(ins[19:16], m_flags);
            end else if ((seq[k] == S_EXECR || seq[k] == S_EXECI) && m_cond &&
                         (ins[8] || is_cmptst(cmd))) begin
                m_flags[3:2] = ALUFlags[3:2];
                if (exp_alu(cmd) == 2'd0 || exp_alu(cmd) == 2'd1) m_flags[1:0] = ALUFlags[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [19:0] ins;
        logic [3:0]  c;
        int          ab;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_state", State, S_FETCH);
            check("rst_we", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // ADDS R1,R2,#5 with ALUFlags Z set, then BEQ taken
        run_instr(20'hE2921, 1'b1, 4'b0100, -1);
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0), 1'b0, 4'b0000, -1);
        // Clear Z, BEQ not taken
        run_instr(20'hE2921, 1'b1, 4'b0000, -1);
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0), 1'b0, 4'b0000, -1);
        // LDR and STR
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'h2, 4'h3), 1'b0, 4'b0000, -1);
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'h2, 4'h3), 1'b0, 4'b0000, -1);
        // CMP R1,#3, then data-processing write to R15
        run_instr(mk(4'hE, 2'b00, 6'b110101, 4'h1, 4'h0), 1'b1, 4'b0110, -1);
        run_instr(mk(4'h1, 2'b10, 6'b100000, 4'h0, 4'h0), 1'b0, 4'b0000, -1);
        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'h1, 4'hF), 1'b0, 4'b0000, -1);
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0), 1'b0, 4'b0000, -1);
        // Reset during MEMWR, then an instruction under cleared CondReg/flags
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'h2, 4'h3), 1'b0, 4'b0000, 3);
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0), 1'b0, 4'b0000, -1);

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            ins = mk(c, 2'($urandom), 6'($urandom), 4'($urandom),
                     ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom));
            ab = ($urandom_range(0, 39) == 0) ? $urandom_range(0, 1) : -1;
            run_instr(ins, 1'b0, 4'b0000, ab);
        end

        @(negedge clk);
        check("final_state", State, S_FETCH);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
